fetch_data_mem_arbiter: RTL and testbench
=========================================

// Module: fetch_data_mem_arbiter
// PURPOSE
//  Shares one memory port between the instruction fetcher (read-only) and the load/store unit (read/write).
//  Sits between the instruction datapath / LSU and the cache.
//  Registers the granted request, forwards the response to the owner, and drains fetches orphaned by a flush.
//  Starvation-bounded data priority.
// PARAMETERS
//  ADDR_WIDTH    32  address width
//  DATA_WIDTH    32  data width; mask width = DATA_WIDTH/8
//  STARVE_LIMIT  4   consecutive ifetch losses before ifetch is forced to win (>=1)
// PORTS
//  clk            in   1    clock
//  rst            in   1    async active-high reset
//  flush_i        in   1    pipeline flush (branch/jalr mispredict)
//  i_read_i       in   1    fetch read request, held until i_resp_o
//  i_address_i    in   AW   fetch address
//  i_resp_o       out  1    fetch read complete
//  i_rdata_o      out  DW   fetch read data
//  d_read_i       in   1    data read request, held until d_resp_o
//  d_write_i      in   1    data write request, held until d_resp_o
//  d_address_i    in   AW   data address
//  d_wdata_i      in   DW   data write data
//  d_wmask_i      in   DW/8 byte enables
//  d_resp_o       out  1    data access complete
//  d_rdata_o      out  DW   data read data
//  mem_read_o     out  1    memory read, held until mem_resp_i
//  mem_write_o    out  1    memory write, held until mem_resp_i
//  mem_address_o  out  AW   memory address
//  mem_wdata_o    out  DW   memory write data
//  mem_wmask_o    out  DW/8 memory byte enables
//  mem_resp_i     in   1    memory transaction done
//  mem_rdata_i    in   DW   memory read data
// BEHAVIOUR
//  Reset:
//   - State IDLE; starve_cnt=0.
//   - All mem_* outputs and latched request fields are 0.
//   - i_resp_o=d_resp_o=0; rdata outputs pass mem_rdata_i (don't-care while resp=0).
//  States:
//   - IDLE: no grant.
//   - I_BUSY: fetch owns the port.
//   - D_BUSY: data owns the port.
//   - I_DRAIN: fetch was flushed; its response is awaited and discarded.
//  IDLE arbitration, evaluated every cycle:
//   - d_rd && d_wr together is illegal; assert in sim, treat as write.
//   - Fetch is eligible only when i_read_i=1 and flush_i=0.
//   - Only data requesting -> D_BUSY.
//   - Only fetch eligible -> I_BUSY.
//   - Both: if starve_cnt==STARVE_LIMIT, fetch wins; otherwise data wins and starve_cnt++ (saturating).
//   - Grant registers address, wdata, wmask and read/write into the mem_* output flops.
//   - mem_* is asserted the cycle after the request is seen (1-cycle grant latency).
//  starve_cnt:
//   - Cleared on fetch grant, or in IDLE when i_read_i=0.
//   - Otherwise holds.
//  Busy states:
//   - mem_* stays stable until mem_resp_i.
//   - On mem_resp_i: mem_read_o/mem_write_o clear in the same edge; next state is IDLE.
//   - Next grant is one cycle later, so there is 1 idle bubble per transaction.
//   - Owner's resp_o = mem_resp_i, combinational, same cycle; rdata_o = mem_rdata_i.
//   - The non-owner's resp_o is always 0.
//  Flush:
//   - I_BUSY with flush_i=1 and mem_resp_i=0: go to I_DRAIN; i_resp_o is 0 from this cycle on.
//   - I_BUSY with flush_i=1 and mem_resp_i=1 in the same cycle: response dropped (i_resp_o=0); go to IDLE.
//   - I_DRAIN: keeps mem_read_o=1 until mem_resp_i, then IDLE; i_resp_o=0 throughout; flush_i ignored.
//   - D_BUSY: flush ignored; the data access completes normally (LSU owns squash).
//   - IDLE: flush blocks the fetch grant that cycle; data may still be granted.
//  Requester dropping a request mid-transaction is illegal (sim assertion); the arbiter completes it anyway.
//  Async reset mid-transaction: returns to IDLE immediately and drops mem_*.
//  The cache shares rst and is reset in the same event.
// STRUCTURE
//  - Package oops_structs: add arb_state_t enum {IDLE, I_BUSY, D_BUSY, I_DRAIN} and mem_req_t struct {read, write, addr, wdata, wmask}.
//  - Single module; no sub-module is warranted.
//  - Next-state and grant logic in one always_comb; state, mem_req_t and starve_cnt in one always_ff.
//  - Output flops are driven from the mem_req_t register.
// TESTING
//  1. Lone fetch 0x60 at cyc0; mem responds cyc3 with 0x00000013.
//     -> mem_read_o 1 in cyc1-3, mem_address_o=0x60.
//     -> i_resp_o=1 and i_rdata_o=0x13 in cyc3; mem_read_o=0 in cyc4.
//  2. Fetch and data read 0x1000 both held from cyc0 (STARVE_LIMIT=4).
//     -> data granted first.
//     -> with 1-cycle mem latency, fetch is granted after 4 data wins; starve_cnt returns to 0.
//  3. Data write 0x2000, wdata 0xDEADBEEF, wmask 0b0011.
//     -> mem_write_o=1 with matching wdata and wmask.
//     -> d_resp_o pulses with mem_resp_i; i_resp_o stays 0.
//  4. Fetch granted; flush_i pulses 1 cycle later; mem_resp_i comes 3 cycles after that.
//     -> I_DRAIN; mem_read_o held through the response; i_resp_o never asserts.
//     -> a new fetch is granted the cycle after the drain completes.
//  5. flush_i and mem_resp_i together in I_BUSY.
//     -> i_resp_o=0; state IDLE next cycle.
//     -> flush_i in D_BUSY: d_resp_o is still delivered.
//  6. rst asserted asynchronously mid D_BUSY.
//     -> mem_write_o and mem_read_o drop without waiting for a clock edge; state IDLE; starve_cnt=0.
//     -> after release, a pending fetch is granted normally.

Source files
------------

// File: rtl/fetch_data_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter:
// arbiter state encoding and the registered memory request bundle.
package oops_structs;

  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;
  localparam int ARB_MW = ARB_DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DRAIN
  } arb_state_t;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [ARB_MW-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/fetch_data_mem_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the
// load/store unit (read/write), with starvation-bounded data priority.
// Ports:
//   clk, rst (async, active high), flush_i
//   i_*  : fetch request in, i_resp_o/i_rdata_o out
//   d_*  : data request in, d_resp_o/d_rdata_o out
//   mem_*: registered request to the cache, mem_resp_i/mem_rdata_i back
module fetch_data_mem_arbiter
  import oops_structs::*;
#(
  parameter int ADDR_WIDTH   = ARB_AW,
  parameter int DATA_WIDTH   = ARB_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    i_read_i,
  input  logic [ADDR_WIDTH-1:0]   i_address_i,
  output logic                    i_resp_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_read_i,
  input  logic                    d_write_i,
  input  logic [ADDR_WIDTH-1:0]   d_address_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_wmask_i,
  output logic                    d_resp_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic [ADDR_WIDTH-1:0]   mem_address_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_resp_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  // The request register is a package struct of fixed width.
  if (ADDR_WIDTH != ARB_AW || DATA_WIDTH != ARB_DW
      || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("arbiter: unsupported parameters");
  end

  arb_state_t    state_q, state_d;
  mem_req_t      req_q, req_d;
  logic [SW-1:0] starve_q, starve_d;

  logic d_req;
  logic i_elig;
  logic d_win;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    starve_d = starve_q;
    d_req    = d_read_i | d_write_i;
    i_elig   = i_read_i & ~flush_i;
    // Data wins unless fetch is eligible and has lost too often.
    d_win    = d_req & ~(i_elig & (starve_q == LIM));
    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d     = D_BUSY;
          // read+write together is treated as a write
          req_d.read  = d_read_i & ~d_write_i;
          req_d.write = d_write_i;
          req_d.addr  = d_address_i;
          req_d.wdata = d_wdata_i;
          req_d.wmask = d_wmask_i;
          if (i_elig && starve_q != LIM) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (i_elig) begin
          state_d     = I_BUSY;
          req_d.read  = 1'b1;
          req_d.write = 1'b0;
          req_d.addr  = i_address_i;
          req_d.wdata = '0;
          req_d.wmask = '0;
          starve_d    = '0;
        end
        if (!i_read_i) begin
          starve_d = '0;
        end
      end
      I_BUSY: begin
        if (mem_resp_i) begin
          state_d     = IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
        end else if (flush_i) begin
          state_d = I_DRAIN;
        end
      end
      D_BUSY, I_DRAIN: begin
        if (mem_resp_i) begin
          state_d     = IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      starve_q <= starve_d;
    end
  end

  assign mem_read_o    = req_q.read;
  assign mem_write_o   = req_q.write;
  assign mem_address_o = req_q.addr;
  assign mem_wdata_o   = req_q.wdata;
  assign mem_wmask_o   = req_q.wmask;

  // A fetch flushed in its response cycle is dropped.
  assign i_resp_o  = (state_q == I_BUSY) & mem_resp_i & ~flush_i;
  assign d_resp_o  = (state_q == D_BUSY) & mem_resp_i;
  assign i_rdata_o = mem_rdata_i;
  assign d_rdata_o = mem_rdata_i;

  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
    !(d_read_i && d_write_i));

  a_d_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == D_BUSY) |-> (d_read_i || d_write_i));

  a_i_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == I_BUSY && !flush_i) |-> i_read_i);

endmodule

// File: tb/tb_fetch_data_mem_arbiter.sv
// Randomized scoreboard bench for fetch_data_mem_arbiter.
// Stimulus process runs a transaction-level model; monitor checks.
module tb_fetch_data_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          i_read_i = 1'b0;
  logic [AW-1:0] i_address_i = '0;
  logic          i_resp_o;
  logic [DW-1:0] i_rdata_o;
  logic          d_read_i = 1'b0;
  logic          d_write_i = 1'b0;
  logic [AW-1:0] d_address_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [MW-1:0] d_wmask_i = '0;
  logic          d_resp_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_address_o;
  logic [DW-1:0] mem_wdata_o;
  logic [MW-1:0] mem_wmask_o;
  logic          mem_resp_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  fetch_data_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .i_read_i(i_read_i), .i_address_i(i_address_i),
    .i_resp_o(i_resp_o), .i_rdata_o(i_rdata_o),
    .d_read_i(d_read_i), .d_write_i(d_write_i),
    .d_address_i(d_address_i), .d_wdata_i(d_wdata_i),
    .d_wmask_i(d_wmask_i), .d_resp_o(d_resp_o),
    .d_rdata_o(d_rdata_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_resp_i(mem_resp_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic          ir;
    logic          dr;
  } cyc_t;

  typedef struct {
    logic          is_d;
    logic [DW-1:0] data;
  } rsp_t;

  cyc_t cq[$];
  rsp_t rq[$];
  int   total = 0;
  int   bad = 0;
  bit   active = 0;
  bit   rst_mid = 0;
  bit   done = 0;
  bit   tmo = 0;

  // owner: 0 none, 1 fetch, 2 data, 3 orphaned fetch
  int            own;
  int            starve;
  int            lat;
  int            force_lat;
  bit            rand_on;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [MW-1:0] m_wm;
  bit            i_pend, d_pend, d_wr;
  logic [AW-1:0] i_a, d_a;
  logic [DW-1:0] d_wd;
  logic [MW-1:0] d_wm;

  task automatic model_reset();
    own = 0; starve = 0; lat = 0;
    m_rd = 0; m_wr = 0; m_addr = '0; m_wd = '0; m_wm = '0;
    i_pend = 0; d_pend = 0; d_wr = 0;
    i_a = '0; d_a = '0; d_wd = '0; d_wm = '0;
  endtask

  function automatic int new_lat();
    return (force_lat >= 0) ? force_lat : int'($urandom_range(3, 0));
  endfunction

  task automatic step();
    cyc_t c;
    rsp_t r;
    bit   resp, fl, f_ok;
    @(negedge clk);
    active = 1;
    if (rand_on) begin
      if (!i_pend && $urandom_range(1, 0) == 1) begin
        i_pend = 1;
        i_a = AW'($urandom) & ~32'h3;
      end
      if (!d_pend && $urandom_range(3, 0) != 0) begin
        d_pend = 1;
        d_wr = 1'($urandom_range(1, 0));
        d_a = AW'($urandom) & ~32'h3;
        d_wd = DW'($urandom);
        d_wm = MW'($urandom_range(15, 1));
      end
    end
    fl = rand_on && ($urandom_range(9, 0) == 0);
    resp = (own != 0) && (lat == 0);
    flush_i = fl;
    i_read_i = i_pend;
    i_address_i = i_a;
    d_read_i = d_pend && !d_wr;
    d_write_i = d_pend && d_wr;
    d_address_i = d_a;
    d_wdata_i = d_wd;
    d_wmask_i = d_wm;
    mem_resp_i = resp;
    mem_rdata_i = DW'($urandom);
    c.rd = m_rd; c.wr = m_wr; c.addr = m_addr;
    c.wdata = m_wd; c.wmask = m_wm;
    c.ir = (own == 1) && resp && !fl;
    c.dr = (own == 2) && resp;
    cq.push_back(c);
    if (c.ir || c.dr) begin
      r.is_d = c.dr;
      r.data = mem_rdata_i;
      rq.push_back(r);
    end
    if (own != 0) begin
      if (resp) begin
        own = 0; m_rd = 0; m_wr = 0;
      end else begin
        if (own == 1 && fl) own = 3;
        lat--;
      end
    end else begin
      f_ok = i_pend && !fl;
      if (d_pend && !(f_ok && starve == LIM)) begin
        own = 2; m_rd = !d_wr; m_wr = d_wr;
        m_addr = d_a; m_wd = d_wd; m_wm = d_wm;
        if (f_ok) starve = (starve < LIM) ? starve + 1 : LIM;
        lat = new_lat();
      end else if (f_ok) begin
        own = 1; m_rd = 1; m_wr = 0;
        m_addr = i_a; m_wd = '0; m_wm = '0;
        starve = 0;
        lat = new_lat();
      end
      if (!i_pend) starve = 0;
    end
    if (c.dr) d_pend = 0;
    if (c.ir || fl) i_pend = 0;
  endtask

  task automatic quiesce();
    int n = 0;
    rand_on = 0;
    while ((i_pend || d_pend || own != 0) && n < 200) begin
      step();
      n++;
    end
    if (i_pend || d_pend || own != 0) tmo = 1;
  endtask

  // stimulus + reference model
  initial begin
    model_reset();
    rand_on = 0;
    force_lat = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    repeat (3) step();
    rand_on = 1;
    repeat (600) step();
    quiesce();
    d_pend = 1; d_wr = 1;
    d_a = 32'h2000; d_wd = 32'hDEADBEEF; d_wm = 4'b0011;
    force_lat = 20;
    step();
    step();
    force_lat = -1;
    #3;
    active = 0;
    rst_mid = 1;
    rst = 1;
    #2;
    model_reset();
    flush_i = 0; i_read_i = 0; d_read_i = 0; d_write_i = 0;
    mem_resp_i = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    rst_mid = 0;
    i_pend = 1;
    i_a = 32'h60;
    rand_on = 1;
    repeat (400) step();
    quiesce();
    repeat (2) step();
    @(posedge clk);
    done = 1;
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  // monitor
  initial begin
    cyc_t c;
    rsp_t r;
    forever begin
      @(negedge clk or posedge rst or posedge done);
      if (done) begin
        chk("cq_left", 32'(cq.size()), 32'd0);
        chk("rq_left", 32'(rq.size()), 32'd0);
        chk("timeout", 32'(tmo), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end else if (rst) begin
        if (rst_mid) begin
          #1;
          chk("rst_rd", 32'(mem_read_o), 32'd0);
          chk("rst_wr", 32'(mem_write_o), 32'd0);
          chk("rst_iresp", 32'(i_resp_o), 32'd0);
          chk("rst_dresp", 32'(d_resp_o), 32'd0);
        end
      end else begin
        #2;
        if (active) begin
          if (cq.size() == 0) begin
            chk("cq_empty", 32'd1, 32'd0);
          end else begin
            c = cq.pop_front();
            chk("mem_rd", 32'(mem_read_o), 32'(c.rd));
            chk("mem_wr", 32'(mem_write_o), 32'(c.wr));
            if (c.rd || c.wr)
              chk("mem_addr", mem_address_o, c.addr);
            if (c.wr) begin
              chk("mem_wdata", mem_wdata_o, c.wdata);
              chk("mem_wmask", 32'(mem_wmask_o), 32'(c.wmask));
            end
            chk("i_resp", 32'(i_resp_o), 32'(c.ir));
            chk("d_resp", 32'(d_resp_o), 32'(c.dr));
          end
          if (i_resp_o || d_resp_o) begin
            if (rq.size() == 0) begin
              chk("rsp_unexp", 32'd1, 32'd0);
            end else begin
              r = rq.pop_front();
              chk("rsp_owner", 32'(d_resp_o), 32'(r.is_d));
              chk("rsp_data", r.is_d ? d_rdata_o : i_rdata_o, r.data);
            end
          end
        end
      end
    end
  end

endmodule
